// File: rtl/spi_frame_ctrl_if.sv
// rtl/spi_frame_ctrl_if.sv - byte handshake and chip-select bundle between frame controller and SPI master
interface spi_frame_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       cs_req;

  modport master (output tx_data, output tx_valid, output cs_req,
                  input  tx_ready, input tx_done);
  modport slave  (input  tx_data, input tx_valid, input cs_req,
                  output tx_ready, output tx_done);
endinterface

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - sequences command + counter-snapshot SPI frames from button pulses
module spi_frame_ctrl #(
  parameter int         COUNT_W      = 16,
  parameter logic [7:0] CMD_BYTE     = 8'hA5,
  parameter int         SETUP_CYCLES = 2,
  parameter int         GAP_CYCLES   = 4
) (
  input  logic               clk_100,
  input  logic               a_rst,
  input  logic               s_rst,
  input  logic               next_count,
  input  logic               start_send,
  spi_frame_ctrl_if.master   spi,
  output logic               busy,
  output logic [COUNT_W-1:0] count_value,
  output logic [7:0]         frames_sent,
  output logic               drop_flag
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SETUP     = 3'd1;
  localparam logic [2:0] SEND      = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam logic [2:0] NUM_BYTES = 3'(COUNT_W / 8);

  logic [2:0]         state;
  logic [COUNT_W-1:0] snapshot;
  logic [2:0]         byte_idx;
  logic [3:0]         tick;
  logic               pending;
  logic [COUNT_W-1:0] shifted;
  logic [2:0]         byte_sel;

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      state       <= IDLE;
      snapshot    <= '0;
      byte_idx    <= '0;
      tick        <= '0;
      pending     <= 1'b0;
      count_value <= '0;
      frames_sent <= '0;
      drop_flag   <= 1'b0;
    end else if (s_rst) begin
      state       <= IDLE;
      snapshot    <= '0;
      byte_idx    <= '0;
      tick        <= '0;
      pending     <= 1'b0;
      count_value <= '0;
      frames_sent <= '0;
      drop_flag   <= 1'b0;
    end else begin
      if (next_count)
        count_value <= count_value + COUNT_W'(1);

      // One request may queue behind an active frame; a further one is lost.
      if (start_send && state != IDLE) begin
        if (pending) drop_flag <= 1'b1;
        else         pending   <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_send || pending) begin
            snapshot <= count_value;
            pending  <= 1'b0;
            byte_idx <= '0;
            tick     <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tick == 4'(SETUP_CYCLES - 1)) state <= SEND;
          else                              tick  <= tick + 4'd1;
        end
        SEND: begin
          if (spi.tx_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (spi.tx_done) begin
            if (byte_idx == NUM_BYTES) begin
              frames_sent <= frames_sent + 8'd1;
              tick        <= '0;
              state       <= GAP;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= SEND;
            end
          end
        end
        GAP: begin
          if (tick == 4'(GAP_CYCLES - 1)) state <= IDLE;
          else                            tick  <= tick + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign spi.cs_req   = (state == SETUP) || (state == SEND) || (state == WAIT_DONE);
  assign spi.tx_valid = (state == SEND);

  // Data byte k (1-based) is snapshot byte NUM_BYTES-k, so the MSB goes first.
  always_comb begin
    byte_sel = NUM_BYTES - byte_idx;
    shifted  = snapshot >> {byte_sel, 3'b000};
    spi.tx_data = 8'h00;
    if (state == SEND)
      spi.tx_data = (byte_idx == 3'd0) ? CMD_BYTE : shifted[7:0];
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb/tb_spi_frame_ctrl.sv - randomized self-checking bench for spi_frame_ctrl
module tb_spi_frame_ctrl;
  localparam int NB    = 2;
  localparam int SETUP = 2;
  localparam int GAP   = 4;

  logic        clk_100 = 1'b0;
  logic        a_rst, s_rst, next_count, start_send;
  logic        busy;
  logic [15:0] count_value;
  logic [7:0]  frames_sent;
  logic        drop_flag;

  spi_frame_ctrl_if spi();

  spi_frame_ctrl #(.COUNT_W(16), .CMD_BYTE(8'hA5), .SETUP_CYCLES(SETUP), .GAP_CYCLES(GAP)) dut (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst),
    .next_count(next_count), .start_send(start_send), .spi(spi),
    .busy(busy), .count_value(count_value), .frames_sent(frames_sent), .drop_flag(drop_flag)
  );

  always #5 clk_100 = ~clk_100;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  // Event/timestamp reference: frame bytes queued at launch, times derived from edge numbers.
  logic [15:0] m_count;
  logic [7:0]  m_frames;
  bit          m_drop, m_pending, in_frame, waiting, last_byte;
  int          idle_from, valid_from, done_at, acc_cnt;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic        obs_valid;
  logic [7:0]  obs_data;
  int          rdy_pct = 100, dmin = 1, dmax = 4;
  bit          spurious = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic bit exp_valid();
    return in_frame && !waiting && (edge_n >= valid_from);
  endfunction

  function automatic bit model_busy();
    return in_frame || m_pending || (edge_n + 1 < idle_from);
  endfunction

  task automatic model_reset();
    m_count = '0; m_frames = '0; m_drop = 0; m_pending = 0;
    in_frame = 0; waiting = 0; last_byte = 0;
    idle_from = 0; valid_from = 0; done_at = 0; acc_cnt = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    bit         v;
    logic [7:0] ed;
    v  = exp_valid();
    ed = v ? exp_q[0] : 8'h00;
    check_eq("cs_req",      32'(spi.cs_req),   32'(in_frame));
    check_eq("tx_valid",    32'(spi.tx_valid), 32'(v));
    check_eq("tx_data",     32'(spi.tx_data),  32'(ed));
    check_eq("busy",        32'(busy),         32'(in_frame || (edge_n + 1 < idle_from)));
    check_eq("count_value", 32'(count_value),  32'(m_count));
    check_eq("frames_sent", 32'(frames_sent),  32'(m_frames));
    check_eq("drop_flag",   32'(drop_flag),    32'(m_drop));
    obs_valid = spi.tx_valid;
    obs_data  = spi.tx_data;
  endtask

  task automatic step(input bit nc, input bit ss, input bit sr = 0);
    bit cur_valid, rdy, dn, idle_now;
    cur_valid = exp_valid();
    rdy = ($urandom_range(99) < rdy_pct);
    dn  = waiting && (done_at == edge_n + 1);
    if (!waiting && spurious && $urandom_range(19) == 0) dn = 1;
    spi.tx_ready = rdy; spi.tx_done = dn;
    next_count = nc; start_send = ss; s_rst = sr;
    @(posedge clk_100);
    edge_n++;
    if (obs_valid && rdy) obs_q.push_back(obs_data);
    if (sr) model_reset();
    else begin
      idle_now = !in_frame && (edge_n >= idle_from);
      if (cur_valid && rdy) begin
        waiting   = 1;
        last_byte = (exp_q.size() == 1);
        void'(exp_q.pop_front());
        done_at   = edge_n + int'($urandom_range(dmax, dmin));
        acc_cnt++;
      end else if (waiting && dn) begin
        waiting = 0;
        if (last_byte) begin
          in_frame  = 0;
          m_frames  = m_frames + 8'd1;
          idle_from = edge_n + GAP + 1;
        end else valid_from = edge_n;
      end
      if (idle_now) begin
        if (ss || m_pending) begin
          exp_q.delete();
          exp_q.push_back(8'hA5);
          for (int k = NB - 1; k >= 0; k--) exp_q.push_back(8'(m_count >> (8 * k)));
          in_frame = 1; waiting = 0; acc_cnt = 0; m_pending = 0;
          valid_from = edge_n + SETUP;
        end
      end else if (ss) begin
        if (m_pending) m_drop = 1;
        else           m_pending = 1;
      end
      if (nc) m_count = m_count + 16'd1;
    end
    #1;
    check_outputs();
  endtask

  task automatic run_idle(input int budget);
    int k = 0;
    while (model_busy() && k < budget) begin
      step(0, 0);
      k++;
    end
    check_eq("idle_reached", 32'(model_busy()), 32'd0);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    check_eq({tag, "_n"}, 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      check_eq({tag, "_b0"}, 32'(obs_q[0]), 32'(b0));
      check_eq({tag, "_b1"}, 32'(obs_q[1]), 32'(b1));
      check_eq({tag, "_b2"}, 32'(obs_q[2]), 32'(b2));
    end
  endtask

  task automatic async_reset();
    a_rst = 1'b1;
    #1;
    check_eq("arst_cs",     32'(spi.cs_req),   32'd0);
    check_eq("arst_valid",  32'(spi.tx_valid), 32'd0);
    check_eq("arst_busy",   32'(busy),         32'd0);
    check_eq("arst_count",  32'(count_value),  32'd0);
    check_eq("arst_frames", 32'(frames_sent),  32'd0);
    check_eq("arst_drop",   32'(drop_flag),    32'd0);
    model_reset();
    obs_valid = 1'b0;
    #1;
    a_rst = 1'b0;
  endtask

  initial begin
    int k;
    a_rst = 1'b1; s_rst = 1'b0; next_count = 1'b0; start_send = 1'b0;
    spi.tx_ready = 1'b0; spi.tx_done = 1'b0;
    model_reset();
    obs_valid = 1'b0; obs_data = 8'h00;
    repeat (3) @(posedge clk_100);
    #1;
    a_rst = 1'b0;
    check_outputs();

    repeat (3) step(1, 0);
    check_eq("count_three", 32'(count_value), 32'd3);
    check_eq("idle_busy",   32'(busy),        32'd0);

    // Plain frame with a fast master.
    while (m_count != 16'h1234) step(1, 0);
    rdy_pct = 100; dmin = 5; dmax = 5;
    obs_q.delete();
    step(0, 1);
    check_eq("cs_rise", 32'(spi.cs_req), 32'd1);
    run_idle(200);
    check_bytes("frame1", 8'hA5, 8'h12, 8'h34);
    check_eq("frames_one", 32'(frames_sent), 32'd1);

    // Master stalls; counter moves during the frame.
    obs_q.delete();
    rdy_pct = 0;
    step(0, 1);
    repeat (SETUP) step(0, 0);
    repeat (10) begin
      step(1, 0);
      check_eq("stall_valid", 32'(spi.tx_valid), 32'd1);
      check_eq("stall_data",  32'(spi.tx_data),  32'hA5);
    end
    rdy_pct = 100;
    run_idle(200);
    check_bytes("frame2", 8'hA5, 8'h12, 8'h34);
    check_eq("count_moved", 32'(count_value), 32'h123E);

    // Queued request plus one dropped request.
    obs_q.delete();
    rdy_pct = 70; dmin = 1; dmax = 6;
    step(0, 1);
    repeat (4) step(0, 0);
    step(0, 1);
    repeat (3) step(0, 0);
    step(0, 1);
    run_idle(400);
    check_eq("drop_set",    32'(drop_flag),    32'd1);
    check_eq("frames_four", 32'(frames_sent),  32'd4);
    check_eq("two_frames",  32'(obs_q.size()), 32'd6);

    // Snapshot precedes a same-cycle increment at wrap.
    while (m_count != 16'hFFFF) step(1, 0);
    obs_q.delete();
    rdy_pct = 100;
    step(1, 1);
    run_idle(200);
    check_bytes("wrap", 8'hA5, 8'hFF, 8'hFF);
    check_eq("count_wrap", 32'(count_value), 32'd0);

    // Async reset while waiting for done of the first data byte.
    obs_q.delete();
    dmin = 5; dmax = 5;
    step(0, 1);
    k = 0;
    while (!(waiting && acc_cnt == 2) && k < 100) begin
      step(0, 0);
      k++;
    end
    check_eq("reach_wait", 32'(waiting && acc_cnt == 2), 32'd1);
    async_reset();
    obs_q.delete();
    step(0, 1);
    run_idle(200);
    check_bytes("fresh", 8'hA5, 8'h00, 8'h00);
    check_eq("fresh_frames", 32'(frames_sent), 32'd1);

    // Random traffic with spurious done strobes and occasional sync reset.
    rdy_pct = 60; dmin = 1; dmax = 6; spurious = 1;
    repeat (3000) step($urandom_range(3) == 0, $urandom_range(24) == 0, $urandom_range(499) == 0);
    spurious = 0;
    run_idle(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
- Sequences SPI transmit frames from the board's button-event pulses.
- `next_count` pulses increment a local counter. A `start_send` pulse launches one frame: a command byte, then a snapshot of the counter, MSB byte first.
- Drives an SPI master through a byte-wide valid/ready handshake plus a per-byte done strobe, and owns chip-select framing and inter-frame spacing.

Parameters:
- COUNT_W, 16, counter width in bits; must be a multiple of 8, range 8..32; frame carries COUNT_W/8 data bytes.
- CMD_BYTE, 8'hA5, first byte of every frame.
- SETUP_CYCLES, 2, clk_100 cycles between cs_req rising and first tx_valid; range 1..15.
- GAP_CYCLES, 4, minimum clk_100 cycles cs_req stays low after a frame; range 1..15.

Ports:
- clk_100  in  1  system clock.
- a_rst  in  1  asynchronous reset, active-high.
- s_rst  in  1  synchronous reset, active-high; same effect as a_rst, applied at the clock edge.
- next_count  in  1  single-cycle pulse; increment counter.
- start_send  in  1  single-cycle pulse; request one frame.
- tx_data  out  8  byte offered to SPI master.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  master accepts byte when tx_valid & tx_ready at posedge.
- tx_done  in  1  single-cycle pulse; master finished shifting the accepted byte.
- cs_req  out  1  frame active; master drives CS_n = ~cs_req.
- busy  out  1  high in any state other than IDLE.
- count_value  out  COUNT_W  live counter.
- frames_sent  out  8  completed-frame counter; wraps 255->0.
- drop_flag  out  1  sticky; a start_send was discarded.

Behaviour:
- Reset (a_rst async, or s_rst sync):
  - All outputs 0, state IDLE, pending 0.
  - Reset mid-frame aborts immediately: cs_req and tx_valid drop.
- Counter:
  - count_value increments on every next_count, in every state.
  - Wraps 2^COUNT_W-1 -> 0.
- States: IDLE, SETUP, SEND, WAIT_DONE, GAP.
- IDLE:
  - On start_send, or pending=1: latch snapshot = count_value as of that cycle, before any same-cycle increment.
  - Clear pending, byte_idx=0, go to SETUP.
  - Next cycle cs_req=1 and busy=1.
- SETUP:
  - cs_req=1 for SETUP_CYCLES cycles, then SEND.
- SEND:
  - tx_valid=1; tx_data = CMD_BYTE when byte_idx=0, else snapshot byte (COUNT_W/8 - byte_idx), MSB first.
  - tx_data is held stable while tx_ready=0; no timeout.
  - On handshake, go to WAIT_DONE; tx_valid=0 the next cycle.
- WAIT_DONE:
  - tx_done is honoured only in this state; ignored elsewhere.
  - On tx_done, if byte_idx = COUNT_W/8: deassert cs_req next cycle, increment frames_sent, go to GAP.
  - Otherwise increment byte_idx and go to SEND; cs_req stays 1.
- GAP:
  - cs_req=0, busy=1 for GAP_CYCLES cycles, then IDLE.
- start_send while busy:
  - If pending=0, set pending=1.
  - If pending=1 already, the request is discarded and drop_flag is set.
  - drop_flag clears only on reset.
- start_send in the GAP cycle that returns to IDLE sets pending; it does not drop.
- Bytes per frame: 1 + COUNT_W/8. tx_valid is never high while cs_req=0.

Test Plan:
- Reset, then 3 next_count pulses -> count_value=3, all TX outputs 0, busy=0.
- Defaults, count=16'h1234, start_send; master ready=1, done 5 cycles after each accept -> bytes A5,12,34 in order; cs_req rises 1 cycle after start; first tx_valid 2 cycles after cs_req; frames_sent=1; cs_req low ≥4 cycles.
- tx_ready held 0 for 10 cycles in SEND -> tx_valid and tx_data=A5 stable throughout; next_count pulses during the frame change count_value but not the transmitted bytes.
- Two start_send pulses mid-frame -> the first sets pending and a second frame follows after GAP; the second sets drop_flag=1; frames_sent=2.
- count=16'hFFFF, next_count and start_send in the same cycle -> frame sends A5,FF,FF; count_value=0.
- a_rst asserted during WAIT_DONE of byte 1 -> cs_req, tx_valid, busy and counters go 0 immediately; a fresh frame after release is correct.
